// File: rtl/reflet_vga_fill_if.sv
// Bundle of host write channel, fill command and framebuffer write port
// shared between the fill scheduler and its environment.
interface reflet_vga_fill_if #(
  parameter int unsigned color_depth = 2,
  parameter int unsigned h_bits      = 7,
  parameter int unsigned v_bits      = 6
);
  logic                   host_write_en;
  logic [h_bits-1:0]      host_h;
  logic [v_bits-1:0]      host_v;
  logic [color_depth-1:0] host_R;
  logic [color_depth-1:0] host_G;
  logic [color_depth-1:0] host_B;

  logic                   fill_start;
  logic [h_bits-1:0]      fill_h0;
  logic [h_bits-1:0]      fill_h1;
  logic [v_bits-1:0]      fill_v0;
  logic [v_bits-1:0]      fill_v1;
  logic [color_depth-1:0] fill_R;
  logic [color_depth-1:0] fill_G;
  logic [color_depth-1:0] fill_B;
  logic                   fill_abort;

  logic                   busy;
  logic                   done;
  logic                   write_en;
  logic [h_bits-1:0]      h_pixel;
  logic [v_bits-1:0]      v_pixel;
  logic [color_depth-1:0] R_out;
  logic [color_depth-1:0] G_out;
  logic [color_depth-1:0] B_out;

  modport master (
    output host_write_en, host_h, host_v, host_R, host_G, host_B,
    output fill_start, fill_h0, fill_h1, fill_v0, fill_v1, fill_R, fill_G, fill_B, fill_abort,
    input  busy, done, write_en, h_pixel, v_pixel, R_out, G_out, B_out
  );

  modport slave (
    input  host_write_en, host_h, host_v, host_R, host_G, host_B,
    input  fill_start, fill_h0, fill_h1, fill_v0, fill_v1, fill_R, fill_G, fill_B, fill_abort,
    output busy, done, write_en, h_pixel, v_pixel, R_out, G_out, B_out
  );
endinterface

// File: rtl/reflet_vga_fill.sv
// Framebuffer write-port scheduler: host writes take priority over a
// row-major rectangle fill engine that emits one pixel per free cycle.
module reflet_vga_fill #(
  parameter int unsigned color_depth = 2,
  parameter int unsigned h_bits      = 7,
  parameter int unsigned v_bits      = 6
) (
  input  logic             clk,
  input  logic             reset,
  reflet_vga_fill_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                 state_q, state_d;
  logic [h_bits-1:0]      h0_q, h0_d, h1_q, h1_d, cur_h_q, cur_h_d;
  logic [v_bits-1:0]      v0_q, v0_d, v1_q, v1_d, cur_v_q, cur_v_d;
  logic [color_depth-1:0] fr_q, fr_d, fg_q, fg_d, fb_q, fb_d;

  logic                   write_en_q, write_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [h_bits-1:0]      h_pixel_q, h_pixel_d;
  logic [v_bits-1:0]      v_pixel_q, v_pixel_d;
  logic [color_depth-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  always_comb begin
    state_d    = state_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    cur_h_d    = cur_h_q;
    cur_v_d    = cur_v_q;
    fr_d       = fr_q;
    fg_d       = fg_q;
    fb_d       = fb_q;
    write_en_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    h_pixel_d  = h_pixel_q;
    v_pixel_d  = v_pixel_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;

    // Host traffic is forwarded in every state, abort cycles included.
    if (bus.host_write_en) begin
      write_en_d = 1'b1;
      h_pixel_d  = bus.host_h;
      v_pixel_d  = bus.host_v;
      r_d        = bus.host_R;
      g_d        = bus.host_G;
      b_d        = bus.host_B;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.fill_start) begin
          h0_d    = bus.fill_h0;
          h1_d    = bus.fill_h1;
          v0_d    = bus.fill_v0;
          v1_d    = bus.fill_v1;
          fr_d    = bus.fill_R;
          fg_d    = bus.fill_G;
          fb_d    = bus.fill_B;
          cur_h_d = bus.fill_h0;
          cur_v_d = bus.fill_v0;
          if ((bus.fill_h1 < bus.fill_h0) || (bus.fill_v1 < bus.fill_v0)) begin
            done_d = 1'b1;
          end else begin
            state_d = StFill;
            busy_d  = 1'b1;
          end
        end
      end
      StFill: begin
        if (bus.fill_abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (!bus.host_write_en) begin
          write_en_d = 1'b1;
          h_pixel_d  = cur_h_q;
          v_pixel_d  = cur_v_q;
          r_d        = fr_q;
          g_d        = fg_q;
          b_d        = fb_q;
          // Equality-only compares keep the cursor from ever passing the last pixel.
          if ((cur_h_q == h1_q) && (cur_v_q == v1_q)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (cur_h_q == h1_q) begin
            cur_h_d = h0_q;
            cur_v_d = cur_v_q + 1'b1;
          end else begin
            cur_h_d = cur_h_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      h0_q       <= '0;
      h1_q       <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      cur_h_q    <= '0;
      cur_v_q    <= '0;
      fr_q       <= '0;
      fg_q       <= '0;
      fb_q       <= '0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      h_pixel_q  <= '0;
      v_pixel_q  <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      cur_h_q    <= cur_h_d;
      cur_v_q    <= cur_v_d;
      fr_q       <= fr_d;
      fg_q       <= fg_d;
      fb_q       <= fb_d;
      write_en_q <= write_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      h_pixel_q  <= h_pixel_d;
      v_pixel_q  <= v_pixel_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.write_en = write_en_q;
  assign bus.h_pixel  = h_pixel_q;
  assign bus.v_pixel  = v_pixel_q;
  assign bus.R_out    = r_q;
  assign bus.G_out    = g_q;
  assign bus.B_out    = b_q;

endmodule

// File: tb/tb_reflet_vga_fill.sv
// Directed plus random stimulus against a pixel-queue reference model of the
// fill scheduler; every output is compared one cycle after each input set.
module tb_reflet_vga_fill;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reflet_vga_fill_if #(.color_depth(2), .h_bits(7), .v_bits(6)) bus ();

  reflet_vga_fill #(.color_depth(2), .h_bits(7), .v_bits(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [6:0] h;
    logic [5:0] v;
  } pix_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   obs_writes;
  int   obs_dones;
  int   busy_cycles;

  // Reference model: a queue of the fill pixels still owed to the framebuffer.
  pix_t       pq[$];
  bit         m_busy;
  logic [1:0] m_r, m_g, m_b;
  logic       exp_we, exp_done, exp_busy;
  logic [6:0] exp_h;
  logic [5:0] exp_v;
  logic [1:0] exp_r, exp_g, exp_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    pix_t p;
    if (reset) begin
      pq.delete();
      m_busy = 0;
      exp_we = 0; exp_done = 0;
      exp_h = 0; exp_v = 0; exp_r = 0; exp_g = 0; exp_b = 0;
    end else begin
      exp_we   = 0;
      exp_done = 0;
      if (bus.host_write_en) begin
        exp_we = 1;
        exp_h = bus.host_h; exp_v = bus.host_v;
        exp_r = bus.host_R; exp_g = bus.host_G; exp_b = bus.host_B;
      end
      if (!m_busy) begin
        if (bus.fill_start) begin
          if (int'(bus.fill_h1) < int'(bus.fill_h0) || int'(bus.fill_v1) < int'(bus.fill_v0)) begin
            exp_done = 1;
          end else begin
            for (int v = int'(bus.fill_v0); v <= int'(bus.fill_v1); v++)
              for (int h = int'(bus.fill_h0); h <= int'(bus.fill_h1); h++)
                pq.push_back({7'(h), 6'(v)});
            m_busy = 1;
            m_r = bus.fill_R; m_g = bus.fill_G; m_b = bus.fill_B;
          end
        end
      end else if (bus.fill_abort) begin
        pq.delete();
        m_busy = 0;
      end else if (!bus.host_write_en) begin
        p = pq.pop_front();
        exp_we = 1;
        exp_h = p.h; exp_v = p.v;
        exp_r = m_r; exp_g = m_g; exp_b = m_b;
        if (pq.size() == 0) begin
          m_busy   = 0;
          exp_done = 1;
        end
      end
    end
    exp_busy = m_busy;

    @(posedge clk);
    #1;
    check_eq("write_en", 32'(bus.write_en), 32'(exp_we));
    check_eq("h_pixel",  32'(bus.h_pixel),  32'(exp_h));
    check_eq("v_pixel",  32'(bus.v_pixel),  32'(exp_v));
    check_eq("rgb_out",  32'({bus.R_out, bus.G_out, bus.B_out}), 32'({exp_r, exp_g, exp_b}));
    check_eq("busy",     32'(bus.busy),     32'(exp_busy));
    check_eq("done",     32'(bus.done),     32'(exp_done));
    obs_writes  += int'(bus.write_en);
    obs_dones   += int'(bus.done);
    busy_cycles += int'(bus.busy);
  endtask

  task automatic set_fill(input int h0, input int h1, input int v0, input int v1,
                          input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
    bus.fill_h0 = 7'(h0); bus.fill_h1 = 7'(h1);
    bus.fill_v0 = 6'(v0); bus.fill_v1 = 6'(v1);
    bus.fill_R = r; bus.fill_G = g; bus.fill_B = b;
  endtask

  task automatic clear_counts();
    obs_writes = 0; obs_dones = 0; busy_cycles = 0;
  endtask

  task automatic start_fill();
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      step();
      n++;
    end
    check_eq("fill_finish_in_budget", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.host_write_en = 0; bus.host_h = 0; bus.host_v = 0;
    bus.host_R = 0; bus.host_G = 0; bus.host_B = 0;
    bus.fill_start = 0; bus.fill_abort = 0;
    set_fill(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    step();
    step();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) step();

    // Small fill, no host traffic
    clear_counts();
    set_fill(2, 4, 1, 2, 2'b10, 2'b01, 2'b00);
    start_fill();
    run_until_idle(20);
    step();
    check_eq("small_fill_writes", 32'(obs_writes), 32'd6);
    check_eq("small_fill_dones", 32'(obs_dones), 32'd1);
    check_eq("small_fill_busy_cycles", 32'(busy_cycles), 32'd6);

    // Same fill with two host writes inserted
    clear_counts();
    start_fill();
    step();
    step();
    bus.host_write_en = 1; bus.host_h = 7'd100; bus.host_v = 6'd50;
    bus.host_R = 2'b11; bus.host_G = 2'b11; bus.host_B = 2'b11;
    step();
    step();
    bus.host_write_en = 0;
    run_until_idle(20);
    step();
    check_eq("host_mix_writes", 32'(obs_writes), 32'd8);
    check_eq("host_mix_dones", 32'(obs_dones), 32'd1);

    // Full screen; edge coordinates must not wrap
    clear_counts();
    set_fill(0, 127, 0, 63, 2'b01, 2'b10, 2'b11);
    start_fill();
    run_until_idle(9000);
    check_eq("full_last_h", 32'(bus.h_pixel), 32'd127);
    check_eq("full_last_v", 32'(bus.v_pixel), 32'd63);
    step();
    check_eq("full_writes", 32'(obs_writes), 32'd8192);
    check_eq("full_dones", 32'(obs_dones), 32'd1);

    // Abort after three writes, then immediate restart
    clear_counts();
    set_fill(0, 9, 3, 3, 2'b11, 2'b00, 2'b01);
    start_fill();
    for (int i = 0; i < 3; i++) step();
    bus.fill_abort = 1;
    step();
    bus.fill_abort = 0;
    check_eq("abort_writes", 32'(obs_writes), 32'd3);
    check_eq("abort_dones", 32'(obs_dones), 32'd0);
    set_fill(10, 11, 5, 5, 2'b01, 2'b01, 2'b01);
    start_fill();
    run_until_idle(20);
    step();

    // Empty rectangle
    clear_counts();
    set_fill(5, 3, 0, 0, 2'b10, 2'b10, 2'b10);
    start_fill();
    step();
    check_eq("empty_writes", 32'(obs_writes), 32'd0);
    check_eq("empty_dones", 32'(obs_dones), 32'd1);
    check_eq("empty_busy_cycles", 32'(busy_cycles), 32'd0);

    // fill_start while busy is ignored
    set_fill(20, 23, 7, 7, 2'b01, 2'b10, 2'b01);
    start_fill();
    set_fill(40, 60, 10, 20, 2'b11, 2'b11, 2'b11);
    bus.fill_start = 1;
    step();
    step();
    bus.fill_start = 0;
    run_until_idle(20);

    // Reset mid-fill
    set_fill(30, 40, 1, 3, 2'b10, 2'b00, 2'b10);
    start_fill();
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int h0, v0;
      reset = ($urandom_range(0, 499) == 0);
      bus.host_write_en = ($urandom_range(0, 9) < 3);
      bus.host_h = 7'($urandom); bus.host_v = 6'($urandom);
      bus.host_R = 2'($urandom); bus.host_G = 2'($urandom); bus.host_B = 2'($urandom);
      bus.fill_start = ($urandom_range(0, 9) < 2);
      bus.fill_abort = ($urandom_range(0, 49) == 0);
      h0 = int'($urandom_range(0, 127));
      v0 = int'($urandom_range(0, 63));
      set_fill(h0,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127))
                                            : ((h0 + 5 > 127) ? 127 : h0 + int'($urandom_range(0, 5))),
               v0,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                            : ((v0 + 3 > 63) ? 63 : v0 + int'($urandom_range(0, 3))),
               2'($urandom), 2'($urandom), 2'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
